// File: rtl/pipe_reg_chain.sv
// Multi-stage operand pipeline register with valid tracking, flush and occupancy count.
// Optional per-stage parity when PIPE_REG_PARITY_EN is defined; DEPTH=0 is a pure bypass.
module pipe_reg_chain #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 1,
  localparam int unsigned OCC_W = (DEPTH == 0) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             vld_in,
  input  logic             par_inj,
  output logic [WIDTH-1:0] out,
  output logic             vld_out,
  output logic [OCC_W-1:0] occ,
  output logic             par_err
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, clk_en, flush, par_inj};

    assign out     = d;
    assign vld_out = vld_in;
    assign occ     = '0;
    assign par_err = 1'b0;
  end else begin : g_pipe
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_shift;
    logic [OCC_W-1:0] occ_q;

    function automatic logic [OCC_W-1:0] popcount(input logic [DEPTH-1:0] v);
      logic [OCC_W-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < DEPTH; i++) c = c + OCC_W'(v[i]);
      return c;
    endfunction

    // Valid vector as it will look after an advance, so occ updates in the same edge.
    always_comb begin
      vld_shift    = '0;
      vld_shift[0] = vld_in;
      for (int unsigned i = 1; i < DEPTH; i++) vld_shift[i] = vld_q[i-1];
    end

    always_ff @(posedge clk) begin
      if (!rst || flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) data_q[i] <= '0;
        vld_q <= '0;
        occ_q <= '0;
      end else if (clk_en) begin
        data_q[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
        vld_q <= vld_shift;
        occ_q <= popcount(vld_shift);
      end
    end

    assign out     = data_q[DEPTH-1];
    assign vld_out = vld_q[DEPTH-1];
    assign occ     = occ_q;

`ifdef PIPE_REG_PARITY_EN
    logic [DEPTH-1:0] par_q;

    always_ff @(posedge clk) begin
      if (!rst || flush) begin
        par_q <= '0;
      end else if (clk_en) begin
        par_q[0] <= ^d ^ par_inj;
        for (int unsigned i = 1; i < DEPTH; i++) par_q[i] <= par_q[i-1];
      end
    end

    assign par_err = vld_out & (^out ^ par_q[DEPTH-1]);
`else
    logic unused_par;
    assign unused_par = par_inj;
    assign par_err    = 1'b0;
`endif
  end

endmodule
